thread_pc_bank: RTL and testbench

- Holds the four per-thread program counters of the fine-grained multithreaded core.
- Feeds the round-robin thread selector's four PC inputs and advances the PC of whichever thread the selector issued.
- Applies branch/jump redirects coming back from execute, and tracks per-thread run/halt status so halted threads stop advancing.
- Sits directly upstream of the thread selector, in a loop with it: the selector's thread id and fetch indication return here.

---
 rtl/thread_pc_bank.sv | 113 +++++++++++
 tb/tb_thread_pc_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_pc_bank.sv
// Per-thread program counters and run/halt state for the 4-thread fetch loop.
// Each thread is an identical slot; the top decodes the tid buses into per-slot strobes.

module thread_pc_slot #(
    parameter int             W        = 8,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         fetch,
    input  logic         redirect,
    input  logic [W-1:0] target,
    input  logic         halt,
    input  logic         resume,
    output logic [W-1:0] pc,
    output logic         running
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    localparam logic [W-1:0] PC_INC = W'(1);

    state_t       state, state_nxt;
    logic [W-1:0] pc_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (halt) state_nxt = HALT;
            HALT:    if (resume && !halt) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        // Redirect lands in any state and beats a same-cycle fetch.
        if (redirect)
            pc_nxt = target;
        else if (fetch && state == RUN)
            pc_nxt = pc + PC_INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            running <= (state_nxt == RUN);
        end
    end
endmodule

module thread_pc_bank #(
    parameter int INSTMEM_LOG2_DEEP = 8,
    parameter int RESET_PC0         = 0,
    parameter int RESET_PC1         = 0,
    parameter int RESET_PC2         = 0,
    parameter int RESET_PC3         = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic                         fetch_valid_i,
    input  logic [1:0]                   fetch_tid_i,
    input  logic                         redirect_valid_i,
    input  logic [1:0]                   redirect_tid_i,
    input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_target_i,
    input  logic                         halt_valid_i,
    input  logic [1:0]                   halt_tid_i,
    input  logic                         resume_valid_i,
    input  logic [1:0]                   resume_tid_i,
    output logic [INSTMEM_LOG2_DEEP-1:0] thread0_pc_o,
    output logic [INSTMEM_LOG2_DEEP-1:0] thread1_pc_o,
    output logic [INSTMEM_LOG2_DEEP-1:0] thread2_pc_o,
    output logic [INSTMEM_LOG2_DEEP-1:0] thread3_pc_o,
    output logic [3:0]                   thread_running_o
);
    localparam int NUM_THREADS = 4;
    localparam int W           = INSTMEM_LOG2_DEEP;

    localparam logic [NUM_THREADS-1:0][W-1:0] RESET_PCS =
        {W'(RESET_PC3), W'(RESET_PC2), W'(RESET_PC1), W'(RESET_PC0)};

    logic [NUM_THREADS-1:0][W-1:0] pc;

    genvar g;
    generate
        for (g = 0; g < NUM_THREADS; g++) begin : g_thr
            thread_pc_slot #(
                .W        (W),
                .RESET_PC (RESET_PCS[g])
            ) u_slot (
                .clk      (clk_i),
                .rst_n    (rst_n_i),
                .start    (start_i),
                .fetch    (fetch_valid_i    && fetch_tid_i    == 2'(g)),
                .redirect (redirect_valid_i && redirect_tid_i == 2'(g)),
                .target   (redirect_target_i),
                .halt     (halt_valid_i     && halt_tid_i     == 2'(g)),
                .resume   (resume_valid_i   && resume_tid_i   == 2'(g)),
                .pc       (pc[g]),
                .running  (thread_running_o[g])
            );
        end
    endgenerate

    assign thread0_pc_o = pc[0];
    assign thread1_pc_o = pc[1];
    assign thread2_pc_o = pc[2];
    assign thread3_pc_o = pc[3];
endmodule

// File: tb/tb_thread_pc_bank.sv
// Directed bench for thread_pc_bank: reset values, fetch advance, wrap,
// redirect priority, halt/resume and asynchronous reset.

module tb_thread_pc_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       fetch_valid;
    logic [1:0] fetch_tid;
    logic       redirect_valid;
    logic [1:0] redirect_tid;
    logic [7:0] redirect_target;
    logic       halt_valid;
    logic [1:0] halt_tid;
    logic       resume_valid;
    logic [1:0] resume_tid;
    logic [7:0] pc0, pc1, pc2, pc3;
    logic [3:0] running;

    int checks = 0;
    int errors = 0;

    thread_pc_bank #(
        .INSTMEM_LOG2_DEEP (8),
        .RESET_PC0         (0),
        .RESET_PC1         (16),
        .RESET_PC2         (32),
        .RESET_PC3         (48)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .start_i           (start),
        .fetch_valid_i     (fetch_valid),
        .fetch_tid_i       (fetch_tid),
        .redirect_valid_i  (redirect_valid),
        .redirect_tid_i    (redirect_tid),
        .redirect_target_i (redirect_target),
        .halt_valid_i      (halt_valid),
        .halt_tid_i        (halt_tid),
        .resume_valid_i    (resume_valid),
        .resume_tid_i      (resume_tid),
        .thread0_pc_o      (pc0),
        .thread1_pc_o      (pc1),
        .thread2_pc_o      (pc2),
        .thread3_pc_o      (pc3),
        .thread_running_o  (running)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; fetch_valid = 1'b0; fetch_tid = 2'd0;
        redirect_valid = 1'b0; redirect_tid = 2'd0; redirect_target = 8'h00;
        halt_valid = 1'b0; halt_tid = 2'd0; resume_valid = 1'b0; resume_tid = 2'd0;
    endtask

    task automatic fetch(input logic [1:0] tid);
        fetch_valid = 1'b1; fetch_tid = tid;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({pc3, pc2, pc1, pc0} !== {8'd48, 8'd32, 8'd16, 8'd0}) begin
            errors++;
            $display("FAIL reset_pcs: got %h %h %h %h expected 30 20 10 00", pc3, pc2, pc1, pc0);
        end
        checks++;
        if (running !== 4'b0000) begin
            errors++;
            $display("FAIL reset_running: got %b expected 0000", running);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        fetch(2'd1);
        checks++;
        if (pc1 !== 8'd16 || running !== 4'b0000) begin
            errors++;
            $display("FAIL idle_fetch: pc1=%h running=%b expected 10 0000", pc1, running);
        end
        halt_valid = 1'b1; halt_tid = 2'd0;
        step();
        halt_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (running !== 4'b1111) begin
            errors++;
            $display("FAIL start_running: got %b expected 1111", running);
        end
        checks++;
        if ({pc3, pc2, pc1, pc0} !== {8'd48, 8'd32, 8'd16, 8'd0}) begin
            errors++;
            $display("FAIL start_pcs: got %h %h %h %h expected 30 20 10 00", pc3, pc2, pc1, pc0);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0][7:0] exp_pc;
        exp_pc = {8'd49, 8'd33, 8'd17, 8'd2};
        fetch(2'd0);
        checks++;
        if (pc0 !== 8'd1) begin
            errors++;
            $display("FAIL rr_first_fetch: pc0=%h expected 01", pc0);
        end
        fetch(2'd1);
        fetch(2'd2);
        fetch(2'd3);
        fetch(2'd0);
        checks++;
        if ({pc3, pc2, pc1, pc0} !== exp_pc) begin
            errors++;
            $display("FAIL rr_pcs: got %h %h %h %h expected %h", pc3, pc2, pc1, pc0, exp_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_tid = 2'd2; redirect_target = 8'hFF;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (pc2 !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_load: pc2=%h expected ff", pc2);
        end
        fetch(2'd2);
        checks++;
        if (pc2 !== 8'h00) begin
            errors++;
            $display("FAIL wrap_increment: pc2=%h expected 00", pc2);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_tid = 2'd1; redirect_target = 8'h40;
        fetch_valid = 1'b1; fetch_tid = 2'd1;
        step();
        checks++;
        if (pc1 !== 8'h40) begin
            errors++;
            $display("FAIL redirect_beats_fetch: pc1=%h expected 40", pc1);
        end
        redirect_tid = 2'd3; redirect_target = 8'h80;
        fetch_tid = 2'd0;
        step();
        redirect_valid = 1'b0; fetch_valid = 1'b0;
        checks++;
        if (pc3 !== 8'h80 || pc0 !== 8'h03 || pc1 !== 8'h40) begin
            errors++;
            $display("FAIL redirect_and_fetch: pc3=%h pc0=%h pc1=%h expected 80 03 40", pc3, pc0, pc1);
        end
    endtask

    task automatic test_halt_resume();
        halt_valid = 1'b1; halt_tid = 2'd2;
        step();
        halt_valid = 1'b0;
        checks++;
        if (running !== 4'b1011) begin
            errors++;
            $display("FAIL halt_running: got %b expected 1011", running);
        end
        fetch(2'd2); fetch(2'd2); fetch(2'd2);
        checks++;
        if (pc2 !== 8'h00 || running[2] !== 1'b0) begin
            errors++;
            $display("FAIL halted_fetch: pc2=%h running2=%b expected 00 0", pc2, running[2]);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (running !== 4'b1011) begin
            errors++;
            $display("FAIL start_in_halt: got %b expected 1011", running);
        end
        halt_valid = 1'b1; halt_tid = 2'd2; resume_valid = 1'b1; resume_tid = 2'd2;
        step();
        halt_valid = 1'b0; resume_valid = 1'b0;
        checks++;
        if (running !== 4'b1011) begin
            errors++;
            $display("FAIL halt_wins: got %b expected 1011", running);
        end
        resume_valid = 1'b1; resume_tid = 2'd2;
        step();
        resume_valid = 1'b0;
        checks++;
        if (running !== 4'b1111) begin
            errors++;
            $display("FAIL resume_running: got %b expected 1111", running);
        end
        fetch(2'd2);
        checks++;
        if (pc2 !== 8'h01) begin
            errors++;
            $display("FAIL resume_fetch: pc2=%h expected 01", pc2);
        end
    endtask

    task automatic test_async_reset();
        fetch_valid = 1'b1; fetch_tid = 2'd3;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc3, pc2, pc1, pc0} !== {8'd48, 8'd32, 8'd16, 8'd0}) begin
            errors++;
            $display("FAIL async_reset_pcs: got %h %h %h %h expected 30 20 10 00", pc3, pc2, pc1, pc0);
        end
        checks++;
        if (running !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_running: got %b expected 0000", running);
        end
        fetch_valid = 1'b0;
        step();
        #2 rst_n = 1'b1;
        fetch(2'd3);
        checks++;
        if (running !== 4'b0000 || pc3 !== 8'd48) begin
            errors++;
            $display("FAIL post_reset_idle: running=%b pc3=%h expected 0000 30", running, pc3);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_round_robin();
        test_wrap();
        test_redirect();
        test_halt_resume();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
